apa102_in: RTL

Receive-side APA102 decoder: samples an external APA102 clock/data pair, which is asynchronous to `clk`, and frames the start frame and LED frames. Each LED frame becomes two 16-bit word writes, presented on the same `data`/`address`/`write_strobe` bus that the SPI receiver drives into `sram_bus`. It is the counterpart of `apa102_out`: it is used for loopback verification of output channels and for capturing an upstream strip controller into frame memory.

---
 rtl/apa102_in.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/apa102_in.sv
// APA102 receive-side decoder: synchronizes an external clock/data pair, frames
// start and LED frames, and emits each LED frame as two 16-bit word writes.
module apa102_in #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int IDLE_TIMEOUT      = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         clock_in,
    input  logic                         data_in,
    input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
    input  logic [ADDRESS_BUS_WIDTH-1:0] led_limit,
    output logic [15:0]                  data,
    output logic [ADDRESS_BUS_WIDTH-1:0] address,
    output logic                         write_strobe,
    output logic                         frame_done_strobe,
    output logic [15:0]                  led_count,
    output logic                         error
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        HUNT,
        SYNCED,
        FRAME
    } state_t;

    state_t state, state_next;

    logic clk_s1, clk_s2, clk_d;
    logic dat_s1, dat_s2;
    logic bit_valid, bit_data;

    logic [5:0]                   zero_cnt;
    logic [4:0]                   bit_cnt;
    logic [31:0]                  shreg;
    logic [IDLE_W-1:0]            idle_cnt;
    logic [ADDRESS_BUS_WIDTH-1:0] base;
    logic [ADDRESS_BUS_WIDTH-1:0] limit;
    logic [15:0]                  led_index;

    logic                         pend;
    logic [15:0]                  low_data;
    logic [ADDRESS_BUS_WIDTH-1:0] low_addr;

    logic [31:0]                  word;
    logic                         word_done;
    logic                         timeout;
    logic                         do_latch;
    logic                         do_end;
    logic                         do_led;
    logic                         do_err;
    logic                         do_load;
    logic                         wr_ok;
    logic [ADDRESS_BUS_WIDTH-1:0] wr_addr;

    // Clock and data share identical synchronizer depth so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1    <= 1'b0;
            clk_s2    <= 1'b0;
            clk_d     <= 1'b0;
            dat_s1    <= 1'b0;
            dat_s2    <= 1'b0;
            bit_valid <= 1'b0;
            bit_data  <= 1'b0;
        end else begin
            clk_s1    <= clock_in;
            clk_s2    <= clk_s1;
            clk_d     <= clk_s2;
            dat_s1    <= data_in;
            dat_s2    <= dat_s1;
            bit_valid <= clk_s2 & ~clk_d;
            bit_data  <= dat_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_latch   = 1'b0;
        do_end     = 1'b0;
        do_led     = 1'b0;
        do_err     = 1'b0;
        do_load    = 1'b0;
        word       = {shreg[30:0], bit_data};
        word_done  = (state == FRAME) && bit_valid && (bit_cnt == 5'd31);
        timeout    = (idle_cnt == IDLE_W'(IDLE_TIMEOUT)) && !bit_valid;
        wr_ok      = 32'(led_index) < 32'(limit);
        wr_addr    = base + ADDRESS_BUS_WIDTH'({led_index, 1'b0});
        if (!enable) begin
            state_next = HUNT;
        end else begin
            case (state)
                HUNT: begin
                    if (bit_valid && !bit_data && zero_cnt == 6'd31) begin
                        state_next = SYNCED;
                        do_latch   = 1'b1;
                    end
                end
                SYNCED: begin
                    if (timeout) begin
                        do_end     = 1'b1;
                        state_next = HUNT;
                    end else if (bit_valid && bit_data) begin
                        do_load    = 1'b1;
                        state_next = FRAME;
                    end
                end
                FRAME: begin
                    if (timeout) begin
                        do_end     = 1'b1;
                        state_next = HUNT;
                    end else if (word_done) begin
                        if (word[31:29] == 3'b111) begin
                            do_led = 1'b1;
                        end else if (word == '0) begin
                            do_end     = 1'b1;
                            do_latch   = 1'b1;
                            state_next = SYNCED;
                        end else begin
                            do_err     = 1'b1;
                            state_next = HUNT;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt <= '0;
            idle_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (bit_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_W'(IDLE_TIMEOUT)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (!enable || state != HUNT) begin
                zero_cnt <= '0;
            end else if (bit_valid) begin
                if (bit_data) begin
                    zero_cnt <= '0;
                end else if (zero_cnt != 6'd32) begin
                    zero_cnt <= zero_cnt + 1'b1;
                end
            end

            if (do_load) begin
                shreg   <= 32'd1;
                bit_cnt <= 5'd1;
            end else if (state == FRAME && state_next == FRAME && bit_valid) begin
                shreg   <= word;
                bit_cnt <= bit_cnt + 1'b1;
            end else if (state_next != FRAME) begin
                bit_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            limit     <= '0;
            led_index <= '0;
            led_count <= '0;
            error     <= 1'b0;
            frame_done_strobe <= 1'b0;
        end else begin
            frame_done_strobe <= do_end;
            if (do_end) begin
                led_count <= led_index;
            end
            if (do_err) begin
                error <= 1'b1;
            end else if (do_latch) begin
                error <= 1'b0;
            end
            if (do_latch) begin
                base      <= start_address;
                limit     <= led_limit;
                led_index <= '0;
            end else if (do_led && led_index != 16'hFFFF) begin
                led_index <= led_index + 1'b1;
            end
        end
    end

    // The low half is held back one cycle; dropping enable cancels it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_strobe <= 1'b0;
            data         <= '0;
            address      <= '0;
            pend         <= 1'b0;
            low_data     <= '0;
            low_addr     <= '0;
        end else if (do_led && wr_ok) begin
            write_strobe <= 1'b1;
            data         <= word[31:16];
            address      <= wr_addr;
            pend         <= 1'b1;
            low_data     <= word[15:0];
            low_addr     <= wr_addr + 1'b1;
        end else if (pend && enable) begin
            write_strobe <= 1'b1;
            data         <= low_data;
            address      <= low_addr;
            pend         <= 1'b0;
        end else begin
            write_strobe <= 1'b0;
            data         <= '0;
            address      <= '0;
            pend         <= 1'b0;
        end
    end

endmodule
